res_collector: RTL and testbench
================================

RES_COLLECTOR -- requirements
Module: res_collector

Interface
REQ-001 Parameter NUM, default 100, SHALL set the number of result items per batch (legal range 2..1024).
REQ-002 Parameter ITEM_WIDTH, default 8, SHALL set the width of each result item.
REQ-003 clk_i  input  1  SHALL be the single clock; all logic samples on its rising edge.
REQ-004 reset_ni  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 res_valid_i  input  1  SHALL mark res_i as valid from the DUT side.
REQ-006 res_i  input  ITEM_WIDTH  SHALL carry the result item.
REQ-007 res_ready_o  output  1  SHALL indicate that the collector accepts an item this cycle.
REQ-008 batch_ack_i  input  1  SHALL be a host pulse that releases a full batch.
REQ-009 result_data_o  output  array [NUM-1:0] of ITEM_WIDTH  SHALL hold the collected items, index = arrival order.
REQ-010 count_o  output  clog2(NUM+1)  SHALL give the number of items stored in the current batch.
REQ-011 recv_en_o  output  1  SHALL toggle once per completed batch.
REQ-012 batch_cnt_o  output  16  SHALL count completed batches, wrapping at 0xFFFF->0.
REQ-013 stall_cnt_o  output  16  SHALL count cycles where res_valid_i=1 and res_ready_o=0, saturating at 0xFFFF.

Function
REQ-014 The FSM SHALL have three states: IDLE, COLLECT and FULL.
REQ-015 IDLE SHALL go to COLLECT on the first clock edge after reset_ni deasserts.
REQ-016 res_ready_o SHALL be 1 exactly when the state is COLLECT; it is a decode of registered state.
REQ-017 Accept: res_valid_i=1 and res_ready_o=1 at an edge SHALL write res_i to result_data_o[wr_ptr] and increment wr_ptr and count_o; both are visible after that edge.
REQ-018 Accepting the item at wr_ptr=NUM-1 SHALL, on the same edge: set wr_ptr to 0, set count_o to NUM, enter FULL, toggle recv_en_o and increment batch_cnt_o.
REQ-019 In FULL, result_data_o and count_o SHALL hold; res_i SHALL be ignored and never dropped silently (the source sees ready=0).
REQ-020 batch_ack_i=1 at an edge in FULL SHALL enter COLLECT and clear count_o to 0; res_ready_o rises after that edge.
REQ-021 batch_ack_i in IDLE or COLLECT SHALL be ignored.
REQ-022 When batch_ack_i and res_valid_i are both 1 in FULL, the item SHALL NOT be accepted, stall_cnt_o SHALL increment, and the state SHALL go to COLLECT.
REQ-023 result_data_o entries SHALL NOT be cleared on a new batch; each entry is overwritten only when its index is written.
REQ-024 Latency: res_i accepted at edge k SHALL appear on result_data_o at edge k, with no additional delay.
REQ-025 The block SHALL accept one item per cycle in COLLECT with no bubbles.

Reset
REQ-026 While reset_ni=0, the following SHALL hold regardless of clk_i:
- state = IDLE and res_ready_o = 0;
- wr_ptr, count_o, recv_en_o, batch_cnt_o and stall_cnt_o = 0;
- every result_data_o entry = 0.
REQ-027 Reset asserted mid-batch SHALL discard the partial batch; after release, collection restarts at index 0.

Verification
REQ-028 Reset release, then NUM=4 and items 0x11,0x22,0x33,0x44 on consecutive cycles -> result_data_o = {0x44,0x33,0x22,0x11}, count_o=4, recv_en_o 0->1, batch_cnt_o=1, res_ready_o=0.
REQ-029 FULL with res_valid_i held 1 for 5 cycles and no ack -> stall_cnt_o=5, data unchanged; then ack -> res_ready_o=1 one cycle later, count_o=0.
REQ-030 Second batch 0xA0..0xA3 after ack -> result_data_o overwritten in order, recv_en_o 1->0, batch_cnt_o=2.
REQ-031 Ack and valid together in FULL -> item not accepted, stall_cnt_o+1, state COLLECT; the item is accepted on the next cycle at index 0.
REQ-032 reset_ni pulsed low after 2 of 4 items -> all outputs 0 immediately; the next 4 items fill indices 0..3.
REQ-033 batch_ack_i pulsed during COLLECT with count_o=1 -> no state change, count_o stays 1.

Source files
------------

// File: rtl/res_collector.sv
// res_collector -- gathers a batch of NUM result items from a valid/ready
// source into a flat register array, then holds the batch until the host
// acknowledges it.
//
// Ports
//   clk_i          rising-edge clock
//   reset_ni       asynchronous active-low reset
//   res_valid_i    source item valid
//   res_i          source item data (ITEM_WIDTH)
//   res_ready_o    collector accepts an item this cycle (state == COLLECT)
//   batch_ack_i    host pulse releasing a full batch
//   result_data_o  collected items, index = arrival order within the batch
//   count_o        items stored in the current batch (0..NUM)
//   recv_en_o      toggles once per completed batch
//   batch_cnt_o    completed batches, wraps at 16 bits
//   stall_cnt_o    cycles with valid=1 and ready=0, saturates at 0xFFFF

// One result entry: loads when its index is written, otherwise holds.
module res_slot #(
    parameter int ITEM_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  we_i,
    input  logic [ITEM_WIDTH-1:0] d_i,
    output logic [ITEM_WIDTH-1:0] q_o
);
    logic [ITEM_WIDTH-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (we_i) q_d = d_i;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) q_q <= '0;
        else           q_q <= q_d;
    end

    assign q_o = q_q;
endmodule

module res_collector #(
    parameter int NUM        = 100,
    parameter int ITEM_WIDTH = 8
) (
    input  logic                                clk_i,
    input  logic                                reset_ni,
    input  logic                                res_valid_i,
    input  logic [ITEM_WIDTH-1:0]               res_i,
    output logic                                res_ready_o,
    input  logic                                batch_ack_i,
    output logic [NUM-1:0][ITEM_WIDTH-1:0]      result_data_o,
    output logic [$clog2(NUM+1)-1:0]            count_o,
    output logic                                recv_en_o,
    output logic [15:0]                         batch_cnt_o,
    output logic [15:0]                         stall_cnt_o
);
    localparam int CW = $clog2(NUM + 1);
    localparam int PW = $clog2(NUM);

    typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            recv_en_q, recv_en_d;
    logic [15:0]     batch_cnt_q, batch_cnt_d;
    logic [15:0]     stall_cnt_q, stall_cnt_d;

    logic            accept;
    logic            last_slot;

    // Ready is a pure decode of the registered state, so the source never
    // sees a combinational path from valid or ack back to ready.
    assign res_ready_o = (state_q == COLLECT);
    assign accept      = res_valid_i && res_ready_o;
    assign last_slot   = (wr_ptr_q == PW'(NUM - 1));

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        recv_en_d   = recv_en_q;
        batch_cnt_d = batch_cnt_q;
        stall_cnt_d = stall_cnt_q;

        // Back-pressure counter covers IDLE and FULL alike, including the
        // ack+valid cycle in FULL where the item is refused.
        if (res_valid_i && !res_ready_o && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;

        unique case (state_q)
            IDLE: state_d = COLLECT;
            COLLECT: begin
                // Host acks here are meaningless and dropped.
                if (accept) begin
                    if (last_slot) begin
                        wr_ptr_d    = '0;
                        count_d     = CW'(NUM);
                        state_d     = FULL;
                        recv_en_d   = ~recv_en_q;
                        batch_cnt_d = batch_cnt_q + 16'd1;
                    end else begin
                        wr_ptr_d = wr_ptr_q + PW'(1);
                        count_d  = count_q + CW'(1);
                    end
                end
            end
            FULL: begin
                if (batch_ack_i) begin
                    state_d = COLLECT;
                    count_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            recv_en_q   <= 1'b0;
            batch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            recv_en_q   <= recv_en_d;
            batch_cnt_q <= batch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Entries are never bulk-cleared between batches; only the indexed slot
    // loads on an accept, which keeps stale data visible until overwritten.
    for (genvar i = 0; i < NUM; i++) begin : g_slot
        res_slot #(.ITEM_WIDTH(ITEM_WIDTH)) u_slot (
            .clk_i    (clk_i),
            .reset_ni (reset_ni),
            .we_i     (accept && (wr_ptr_q == PW'(i))),
            .d_i      (res_i),
            .q_o      (result_data_o[i])
        );
    end

    assign count_o     = count_q;
    assign recv_en_o   = recv_en_q;
    assign batch_cnt_o = batch_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
endmodule

// File: tb/tb_res_collector.sv
module tb_res_collector;
    localparam int NUM = 4;
    localparam int IW  = 8;

    logic                   clk_i = 1'b0;
    logic                   reset_ni = 1'b0;
    logic                   res_valid_i = 1'b0;
    logic [IW-1:0]          res_i = '0;
    logic                   batch_ack_i = 1'b0;
    logic                   res_ready_o;
    logic [NUM-1:0][IW-1:0] result_data_o;
    logic [2:0]             count_o;
    logic                   recv_en_o;
    logic [15:0]            batch_cnt_o;
    logic [15:0]            stall_cnt_o;

    res_collector #(.NUM(NUM), .ITEM_WIDTH(IW)) dut (
        .clk_i         (clk_i),
        .reset_ni      (reset_ni),
        .res_valid_i   (res_valid_i),
        .res_i         (res_i),
        .res_ready_o   (res_ready_o),
        .batch_ack_i   (batch_ack_i),
        .result_data_o (result_data_o),
        .count_o       (count_o),
        .recv_en_o     (recv_en_o),
        .batch_cnt_o   (batch_cnt_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: a batch buffer described by "has the first edge
    // after reset happened", "is the batch waiting for the host", and the
    // number of items held so far.
    bit          m_started;
    bit          m_waiting;
    int          m_items;
    logic [IW-1:0] m_mem [NUM];
    bit          m_toggle;
    int          m_batches;
    int          m_stalls;

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_started = 0;
        m_waiting = 0;
        m_items   = 0;
        m_toggle  = 0;
        m_batches = 0;
        m_stalls  = 0;
        for (int i = 0; i < NUM; i++) m_mem[i] = '0;
    endtask

    task automatic model_edge(input bit v, input logic [IW-1:0] d, input bit a);
        bit can_take;
        can_take = m_started && !m_waiting;
        if (v && !can_take && m_stalls < 65535) m_stalls++;
        if (!m_started) begin
            m_started = 1;
        end else if (m_waiting) begin
            if (a) begin
                m_waiting = 0;
                m_items   = 0;
            end
        end else if (v) begin
            m_mem[m_items] = d;
            m_items++;
            if (m_items == NUM) begin
                m_waiting = 1;
                m_toggle  = !m_toggle;
                m_batches = (m_batches + 1) % 65536;
            end
        end
    endtask

    task automatic check_all(input string ph);
        logic [NUM*IW-1:0] exp_data;
        for (int i = 0; i < NUM; i++) exp_data[i*IW +: IW] = m_mem[i];
        chk({ph, ".ready"}, 64'(res_ready_o), 64'(m_started && !m_waiting));
        chk({ph, ".count"}, 64'(count_o),     64'(m_items));
        chk({ph, ".recv"},  64'(recv_en_o),   64'(m_toggle));
        chk({ph, ".batch"}, 64'(batch_cnt_o), 64'(m_batches));
        chk({ph, ".stall"}, 64'(stall_cnt_o), 64'(m_stalls));
        chk({ph, ".data"},  64'(result_data_o), 64'(exp_data));
    endtask

    // Drive inputs just after an edge, advance one edge, check #1 later.
    task automatic step(input string ph, input bit v, input logic [IW-1:0] d, input bit a);
        res_valid_i = v;
        res_i       = d;
        batch_ack_i = a;
        @(posedge clk_i);
        model_edge(v, d, a);
        #1;
        check_all(ph);
    endtask

    task automatic pulse_reset(input string ph);
        reset_ni    = 1'b0;
        res_valid_i = 1'b0;
        batch_ack_i = 1'b0;
        #2;
        model_reset();
        check_all(ph);
        @(posedge clk_i);
        #1;
        reset_ni = 1'b1;
    endtask

    initial begin
        model_reset();
        #2;
        check_all("por");
        @(posedge clk_i);
        #1;
        reset_ni = 1'b1;

        // First batch 11..44, preceded by the IDLE->COLLECT edge.
        step("idle", 0, 8'h00, 0);
        step("b1_0", 1, 8'h11, 0);
        step("b1_1", 1, 8'h22, 0);
        step("b1_2", 1, 8'h33, 0);
        step("b1_3", 1, 8'h44, 0);
        chk("b1_full_data", 64'(result_data_o), 64'h44332211);

        // Held FULL with valid up: five stalls, data frozen.
        for (int i = 0; i < 5; i++) step("full_stall", 1, 8'(8'hE0 + i), 0);
        chk("stall5", 64'(stall_cnt_o), 64'd5);
        step("ack1", 0, 8'h00, 1);
        chk("ack1_ready", 64'(res_ready_o), 64'd1);

        // Second batch overwrites in order.
        for (int i = 0; i < 4; i++) step("b2", 1, 8'(8'hA0 + i), 0);
        chk("b2_data", 64'(result_data_o), 64'hA3A2A1A0);
        chk("b2_batch", 64'(batch_cnt_o), 64'd2);

        // Ack and valid together: refused item, then taken at index 0.
        step("ack_valid", 1, 8'h55, 1);
        step("after_ack", 1, 8'h55, 0);
        chk("idx0", 64'(result_data_o[0]), 64'h55);
        step("partial", 1, 8'h66, 0);

        // Reset mid-batch after two items.
        pulse_reset("mid_rst");
        step("rst_idle", 0, 8'h00, 0);
        for (int i = 0; i < 4; i++) step("b3", 1, 8'(i + 1), 0);
        chk("b3_data", 64'(result_data_o), 64'h04030201);

        // Ack ignored during COLLECT.
        step("ack3", 0, 8'h00, 1);
        step("one", 1, 8'h77, 0);
        step("ack_collect", 0, 8'h00, 1);
        chk("ack_collect_cnt", 64'(count_o), 64'd1);

        // Randomized traffic with occasional host acks.
        for (int n = 0; n < 400; n++) begin
            step("rnd", ($urandom % 4) != 0, 8'($urandom), ($urandom % 4) == 0);
        end

        res_valid_i = 1'b0;
        batch_ack_i = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
